// File: rtl/riscv_dtm_dmi.sv
// RISC-V JTAG Debug Transport Module: IDCODE/DTMCS/DMI/BYPASS DRs plus a DMI request/response master.
// Optional macro RISCV_DTM_DMI_TIMEOUT_EN adds TIMEOUT_CYCLES and a watchdog on outstanding DMI accesses.
module riscv_dtm_dmi #(
  parameter logic [31:0] IDCODE    = 32'h1DEAD3FF,
  parameter int          IR_WIDTH  = 5,
  parameter int          ABITS     = 7,
  parameter int          IDLE_HINT = 1
`ifdef RISCV_DTM_DMI_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                tck_i,
  input  logic                ntrst_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  input  logic                capture_dr_i,
  input  logic                shift_dr_i,
  input  logic                update_dr_i,
  input  logic [IR_WIDTH-1:0] ir_i,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  output logic [ABITS-1:0]    dmi_req_addr_o,
  output logic [31:0]         dmi_req_data_o,
  output logic [1:0]          dmi_req_op_o,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o,
  input  logic [31:0]         dmi_resp_data_i,
  input  logic                dmi_resp_err_i
);

  localparam int DMI_W = ABITS + 34;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(32'h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(32'h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(32'h11);

  localparam logic [5:0] ABITS_FIELD = 6'(ABITS);
  localparam logic [2:0] IDLE_FIELD  = (IDLE_HINT > 7) ? 3'd7 : 3'(IDLE_HINT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]      idcode_sr;
  logic [31:0]      dtmcs_sr;
  logic [DMI_W-1:0] dmi_sr;
  logic             bypass_sr;

  logic [1:0]       state_reg, state_next;
  logic [1:0]       sticky_err_reg, sticky_err_next;
  logic [ABITS-1:0] last_addr_reg, last_addr_next;
  logic [31:0]      last_data_reg, last_data_next;
  logic [ABITS-1:0] req_addr_reg, req_addr_next;
  logic [31:0]      req_data_reg, req_data_next;
  logic [1:0]       req_op_reg, req_op_next;

  logic sel_idcode, sel_dtmcs, sel_dmi;
  logic dmi_reset, dmi_hard_reset, dmi_start;

  assign sel_idcode = (ir_i == IR_IDCODE);
  assign sel_dtmcs  = (ir_i == IR_DTMCS);
  assign sel_dmi    = (ir_i == IR_DMI);

  assign dmi_hard_reset = update_dr_i && sel_dtmcs && dtmcs_sr[17];
  assign dmi_reset      = update_dr_i && sel_dtmcs && dtmcs_sr[16];
  assign dmi_start      = update_dr_i && sel_dmi && (sticky_err_reg == 2'd0) &&
                          ((dmi_sr[1:0] == 2'd1) || (dmi_sr[1:0] == 2'd2));

  always_comb begin
    tdo_o = bypass_sr;
    if (sel_idcode)     tdo_o = idcode_sr[0];
    else if (sel_dtmcs) tdo_o = dtmcs_sr[0];
    else if (sel_dmi)   tdo_o = dmi_sr[0];
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      idcode_sr <= '0;
      dtmcs_sr  <= '0;
      dmi_sr    <= '0;
      bypass_sr <= 1'b0;
    end else begin
      if (capture_dr_i) begin
        if (sel_idcode) idcode_sr <= IDCODE;
        if (sel_dtmcs)  dtmcs_sr  <= {14'b0, 3'b000, IDLE_FIELD, sticky_err_reg, ABITS_FIELD, 4'd1};
        // A capture while busy reports the busy code even though sticky_err only updates next cycle
        if (sel_dmi)    dmi_sr    <= {last_addr_reg, last_data_reg,
                                      (state_reg != S_IDLE) ? 2'd3 : sticky_err_reg};
        if (!sel_idcode && !sel_dtmcs && !sel_dmi) bypass_sr <= 1'b0;
      end else if (shift_dr_i) begin
        if (sel_idcode) idcode_sr <= {tdi_i, idcode_sr[31:1]};
        if (sel_dtmcs)  dtmcs_sr  <= {tdi_i, dtmcs_sr[31:1]};
        if (sel_dmi)    dmi_sr    <= {tdi_i, dmi_sr[DMI_W-1:1]};
        if (!sel_idcode && !sel_dtmcs && !sel_dmi) bypass_sr <= tdi_i;
      end
    end
  end

`ifdef RISCV_DTM_DMI_TIMEOUT_EN
  logic [31:0] timeout_cnt_reg;
  logic        timeout_hit;

  assign timeout_hit = (state_reg != S_IDLE) && (timeout_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i)
      timeout_cnt_reg <= '0;
    else if ((state_next != state_reg) || (state_reg == S_IDLE))
      timeout_cnt_reg <= '0;
    else
      timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
  end
`endif

  always_comb begin
    state_next      = state_reg;
    sticky_err_next = sticky_err_reg;
    last_addr_next  = last_addr_reg;
    last_data_next  = last_data_reg;
    req_addr_next   = req_addr_reg;
    req_data_next   = req_data_reg;
    req_op_next     = req_op_reg;

    case (state_reg)
      S_IDLE: begin
        if (dmi_start) begin
          state_next     = S_REQ;
          last_addr_next = dmi_sr[DMI_W-1:34];
          req_addr_next  = dmi_sr[DMI_W-1:34];
          req_data_next  = dmi_sr[33:2];
          req_op_next    = dmi_sr[1:0];
        end
      end
      S_REQ: begin
        if (dmi_req_ready_i) state_next = S_RESP;
      end
      S_RESP: begin
        if (dmi_resp_valid_i) begin
          state_next = S_IDLE;
          if (req_op_reg == 2'd1) last_data_next = dmi_resp_data_i;
          if (dmi_resp_err_i && (sticky_err_next == 2'd0)) sticky_err_next = 2'd2;
        end
      end
      default: state_next = S_IDLE;
    endcase

`ifdef RISCV_DTM_DMI_TIMEOUT_EN
    if (timeout_hit) begin
      state_next = S_IDLE;
      if (sticky_err_next == 2'd0) sticky_err_next = 2'd2;
    end
`endif

    if (capture_dr_i && sel_dmi && (state_reg != S_IDLE) && (sticky_err_next == 2'd0))
      sticky_err_next = 2'd3;

    // Hard reset abandons the access outright, so a response landing this cycle is dropped
    if (dmi_hard_reset) begin
      state_next      = S_IDLE;
      sticky_err_next = 2'd0;
      last_data_next  = last_data_reg;
    end else if (dmi_reset) begin
      sticky_err_next = 2'd0;
    end
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      state_reg      <= S_IDLE;
      sticky_err_reg <= 2'd0;
      last_addr_reg  <= '0;
      last_data_reg  <= '0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_op_reg     <= 2'd0;
    end else begin
      state_reg      <= state_next;
      sticky_err_reg <= sticky_err_next;
      last_addr_reg  <= last_addr_next;
      last_data_reg  <= last_data_next;
      req_addr_reg   <= req_addr_next;
      req_data_reg   <= req_data_next;
      req_op_reg     <= req_op_next;
    end
  end

  assign dmi_req_valid_o  = (state_reg == S_REQ);
  assign dmi_resp_ready_o = (state_reg == S_RESP);
  assign dmi_req_addr_o   = req_addr_reg;
  assign dmi_req_data_o   = req_data_reg;
  assign dmi_req_op_o     = req_op_reg;

endmodule

// File: tb/tb_riscv_dtm_dmi.sv
// Directed bench for riscv_dtm_dmi: JTAG DR scans against hand-computed values and a simple DM responder.
module tb_riscv_dtm_dmi;

  logic        tck_i = 1'b0;
  logic        ntrst_i = 1'b0;
  logic        tdi_i = 1'b0;
  logic        tdo_o;
  logic        capture_dr_i = 1'b0;
  logic        shift_dr_i = 1'b0;
  logic        update_dr_i = 1'b0;
  logic [4:0]  ir_i = 5'd0;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  logic [6:0]  dmi_req_addr_o;
  logic [31:0] dmi_req_data_o;
  logic [1:0]  dmi_req_op_o;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i = 32'd0;
  logic        dmi_resp_err_i = 1'b0;

  logic        dm_enable = 1'b0;
  logic        dm_err = 1'b0;
  logic [31:0] dm_rdata = 32'd0;

  int checks = 0;
  int failures = 0;
  logic [63:0] dout;

  riscv_dtm_dmi dut (
    .tck_i           (tck_i),
    .ntrst_i         (ntrst_i),
    .tdi_i           (tdi_i),
    .tdo_o           (tdo_o),
    .capture_dr_i    (capture_dr_i),
    .shift_dr_i      (shift_dr_i),
    .update_dr_i     (update_dr_i),
    .ir_i            (ir_i),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_req_addr_o  (dmi_req_addr_o),
    .dmi_req_data_o  (dmi_req_data_o),
    .dmi_req_op_o    (dmi_req_op_o),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i (dmi_resp_data_i),
    .dmi_resp_err_i  (dmi_resp_err_i)
  );

  always #5 tck_i = ~tck_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // Capture, n shifts, update; returns at the falling edge right after the update edge
  task automatic dr_scan(input logic [4:0] ir, input int n, input logic [63:0] din,
                         output logic [63:0] dout_o);
    dout_o = '0;
    @(negedge tck_i);
    ir_i = ir;
    capture_dr_i = 1'b1;
    @(negedge tck_i);
    capture_dr_i = 1'b0;
    shift_dr_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      tdi_i = din[i];
      dout_o[i] = tdo_o;
      @(negedge tck_i);
    end
    shift_dr_i = 1'b0;
    tdi_i = 1'b0;
    update_dr_i = 1'b1;
    @(negedge tck_i);
    update_dr_i = 1'b0;
    $display("scan ir=0x%02h len=%0d in=0x%0h out=0x%0h", ir, n, din, dout_o);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((dmi_req_valid_o || dmi_resp_ready_o) && n < 20) begin
      @(negedge tck_i);
      n++;
    end
    check(tag, {62'b0, dmi_req_valid_o, dmi_resp_ready_o}, 64'd0);
  endtask

  // Debug Module stand-in: ready whenever enabled, responds one cycle after acceptance
  initial begin
    forever begin
      @(negedge tck_i);
      dmi_resp_valid_i = dm_enable && dmi_resp_ready_o;
      dmi_resp_data_i  = dm_rdata;
      dmi_resp_err_i   = dm_err;
      dmi_req_ready_i  = dm_enable && dmi_req_valid_o;
    end
  end

  initial begin
    #12;
    check("rst_req_valid", {63'b0, dmi_req_valid_o}, 64'd0);
    check("rst_resp_ready", {63'b0, dmi_resp_ready_o}, 64'd0);
    check("rst_payload", {23'b0, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, 64'd0);
    check("rst_tdo", {63'b0, tdo_o}, 64'd0);
    @(negedge tck_i);
    ntrst_i = 1'b1;

    dr_scan(5'h01, 32, 64'd0, dout);
    check("idcode", {32'b0, dout[31:0]}, 64'h1DEAD3FF);
    dr_scan(5'h05, 8, 64'hB5, dout);
    check("bypass_unused", {56'b0, dout[7:0]}, 64'h6A);
    dr_scan(5'h1F, 8, 64'h3C, dout);
    check("bypass_ones", {56'b0, dout[7:0]}, 64'h78);
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_reset", {32'b0, dout[31:0]}, 64'h1071);

    // Write with an always-ready DM, minimum latency
    dm_enable = 1'b1;
    dm_rdata = 32'hDEADBEEF;
    dr_scan(5'h11, 41, mk_dmi(7'h10, 32'h80000001, 2'd2), dout);
    check("wr_valid", {63'b0, dmi_req_valid_o}, 64'd1);
    check("wr_payload", {23'b0, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o},
          mk_dmi(7'h10, 32'h80000001, 2'd2));
    @(negedge tck_i);
    check("wr_resp_phase", {62'b0, dmi_req_valid_o, dmi_resp_ready_o}, 64'd1);
    @(negedge tck_i);
    check("wr_idle", {62'b0, dmi_req_valid_o, dmi_resp_ready_o}, 64'd0);
    dr_scan(5'h11, 41, 64'd0, dout);
    check("wr_capture", dout, mk_dmi(7'h10, 32'h0, 2'd0));

    // Read
    dm_rdata = 32'h00000C82;
    dr_scan(5'h11, 41, mk_dmi(7'h11, 32'h0, 2'd1), dout);
    wait_idle("rd_done");
    dr_scan(5'h11, 41, 64'd0, dout);
    check("rd_capture", dout, mk_dmi(7'h11, 32'h00000C82, 2'd0));

    // Busy: DM never ready
    dm_enable = 1'b0;
    dr_scan(5'h11, 41, mk_dmi(7'h05, 32'h12345678, 2'd2), dout);
    check("busy_payload", {23'b0, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o},
          mk_dmi(7'h05, 32'h12345678, 2'd2));
    dr_scan(5'h11, 41, mk_dmi(7'h06, 32'h0000AAAA, 2'd2), dout);
    check("busy_capture", dout, mk_dmi(7'h05, 32'h00000C82, 2'd3));
    check("busy_ignored", {23'b0, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o},
          mk_dmi(7'h05, 32'h12345678, 2'd2));
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_busy", {32'b0, dout[31:0]}, 64'h1C71);
    dr_scan(5'h10, 32, 64'h10000, dout);
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_dmireset", {32'b0, dout[31:0]}, 64'h1071);
    dm_enable = 1'b1;
    wait_idle("busy_drain");

    // Error response
    dm_rdata = 32'h00000055;
    dm_err = 1'b1;
    dr_scan(5'h11, 41, mk_dmi(7'h20, 32'h0, 2'd1), dout);
    wait_idle("err_done");
    dm_err = 1'b0;
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_err", {32'b0, dout[31:0]}, 64'h1871);
    dr_scan(5'h11, 41, mk_dmi(7'h21, 32'h0, 2'd1), dout);
    check("err_capture", dout, mk_dmi(7'h20, 32'h00000055, 2'd2));
    check("err_blocks_req", {63'b0, dmi_req_valid_o}, 64'd0);
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_err_sticky", {32'b0, dout[31:0]}, 64'h1871);

    // Hard reset, both while idle and while a request is outstanding
    dr_scan(5'h10, 32, 64'h20000, dout);
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_hardreset", {32'b0, dout[31:0]}, 64'h1071);
    dm_enable = 1'b0;
    dr_scan(5'h11, 41, mk_dmi(7'h30, 32'h0000BEEF, 2'd2), dout);
    check("hr_req_valid", {63'b0, dmi_req_valid_o}, 64'd1);
    dr_scan(5'h10, 32, 64'h20000, dout);
    check("hr_withdrawn", {62'b0, dmi_req_valid_o, dmi_resp_ready_o}, 64'd0);
    dr_scan(5'h10, 32, 64'd0, dout);
    check("dtmcs_after_hr", {32'b0, dout[31:0]}, 64'h1071);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
